// File: rtl/adma_pkg.sv
// Shared encodings and FSM state type for the ADMA transaction splitter.
package adma_pkg;

    localparam logic [1:0] ADMA_BURST_FIXED = 2'b00;
    localparam logic [1:0] ADMA_BURST_INCR  = 2'b01;
    localparam int         ADMA_4KB         = 4096;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE,
        DONE
    } adma_spl_st_e;

    // Only the FIXED encoding is special; the reserved encodings behave as INCR.
    function automatic logic adma_is_fixed(input logic [1:0] burst);
        return burst == ADMA_BURST_FIXED;
    endfunction

endpackage

// File: rtl/adma_burst_len_calc.sv
// Combinational burst length: min(remaining, max burst, source 4KB room, destination 4KB room).
module adma_burst_len_calc
    import adma_pkg::*;
#(
    parameter int LEN_W     = 21,
    parameter int ATX_LEN_W = 8,
    parameter int BEAT_SH   = 5
) (
    input  logic [LEN_W-1:0] remaining,
    input  logic [11:0]      src_off,
    input  logic [11:0]      dst_off,
    input  logic             src_fixed,
    input  logic             dst_fixed,
    output logic [LEN_W-1:0] len
);

    localparam int CW0 = (LEN_W > ATX_LEN_W + 1) ? LEN_W : ATX_LEN_W + 1;
    localparam int CW  = (CW0 > 13) ? CW0 : 13;
    localparam logic [CW-1:0] MAX_BEATS = CW'(1) << ATX_LEN_W;

    logic [12:0]   src_room13;
    logic [12:0]   dst_room13;
    logic [CW-1:0] src_room;
    logic [CW-1:0] dst_room;
    logic [CW-1:0] min_len;

    // Room is at least one beat because addresses are beat-aligned.
    always_comb begin
        src_room13 = (13'(ADMA_4KB) - {1'b0, src_off}) >> BEAT_SH;
        dst_room13 = (13'(ADMA_4KB) - {1'b0, dst_off}) >> BEAT_SH;
        src_room   = src_fixed ? MAX_BEATS : CW'(src_room13);
        dst_room   = dst_fixed ? MAX_BEATS : CW'(dst_room13);
        min_len    = CW'(remaining);
        if (MAX_BEATS < min_len) min_len = MAX_BEATS;
        if (src_room < min_len)  min_len = src_room;
        if (dst_room < min_len)  min_len = dst_room;
        len        = LEN_W'(min_len);
    end

endmodule

// File: rtl/adma_atx_splitter.sv
// Splits a channel descriptor into AXI bursts bounded by max length and 4KB pages on both sides.
module adma_atx_splitter
    import adma_pkg::*;
#(
    parameter  int DMA_CHN_NUM   = 4,
    parameter  int SRC_ADDR_W    = 32,
    parameter  int DST_ADDR_W    = 32,
    parameter  int MST_ID_W      = 5,
    parameter  int ATX_LEN_W     = 8,
    parameter  int ATX_DATA_W    = 256,
    parameter  int XFER_LEN_W    = 20,
    localparam int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DMA_CHN_NUM_W-1:0] desc_chn_id,
    input  logic [MST_ID_W-1:0]      desc_arid,
    input  logic [MST_ID_W-1:0]      desc_awid,
    input  logic [SRC_ADDR_W-1:0]    desc_src_addr,
    input  logic [DST_ADDR_W-1:0]    desc_dst_addr,
    input  logic [XFER_LEN_W-1:0]    desc_beats,
    input  logic [1:0]               desc_arburst,
    input  logic [1:0]               desc_awburst,
    input  logic                     desc_vld,
    output logic                     desc_rdy,
    output logic [DMA_CHN_NUM_W-1:0] atx_chn_id,
    output logic [MST_ID_W-1:0]      atx_arid,
    output logic [MST_ID_W-1:0]      atx_awid,
    output logic [SRC_ADDR_W-1:0]    atx_araddr,
    output logic [ATX_LEN_W-1:0]     atx_arlen,
    output logic [1:0]               atx_arburst,
    output logic [DST_ADDR_W-1:0]    atx_awaddr,
    output logic [ATX_LEN_W-1:0]     atx_awlen,
    output logic [1:0]               atx_awburst,
    output logic                     atx_vld,
    input  logic                     atx_rdy,
    output logic                     desc_done,
    output logic [DMA_CHN_NUM_W-1:0] desc_done_chn,
    output logic                     busy
);

    localparam int BEAT_SH = $clog2(ATX_DATA_W / 8);
    localparam int LEN_W   = XFER_LEN_W + 1;
    localparam logic [SRC_ADDR_W-1:0] SRC_LOW = SRC_ADDR_W'((1 << BEAT_SH) - 1);
    localparam logic [DST_ADDR_W-1:0] DST_LOW = DST_ADDR_W'((1 << BEAT_SH) - 1);

    adma_spl_st_e     state;
    adma_spl_st_e     next_state;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] calc_len;
    logic [LEN_W-1:0] rem_next;
    logic             src_fixed;
    logic             dst_fixed;

    assign src_fixed = adma_is_fixed(atx_arburst);
    assign dst_fixed = adma_is_fixed(atx_awburst);
    assign rem_next  = remaining - len_q;

    adma_burst_len_calc #(
        .LEN_W     (LEN_W),
        .ATX_LEN_W (ATX_LEN_W),
        .BEAT_SH   (BEAT_SH)
    ) u_len_calc (
        .remaining (remaining),
        .src_off   (atx_araddr[11:0]),
        .dst_off   (atx_awaddr[11:0]),
        .src_fixed (src_fixed),
        .dst_fixed (dst_fixed),
        .len       (calc_len)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (desc_vld) next_state = (desc_beats == '0) ? DONE : CALC;
            CALC:    next_state = ISSUE;
            ISSUE:   if (atx_rdy) next_state = (rem_next == '0) ? DONE : CALC;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Burst fields stay registered so they are stable for the whole ISSUE phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            atx_chn_id  <= '0;
            atx_arid    <= '0;
            atx_awid    <= '0;
            atx_araddr  <= '0;
            atx_awaddr  <= '0;
            atx_arburst <= '0;
            atx_awburst <= '0;
            atx_arlen   <= '0;
            remaining   <= '0;
            len_q       <= '0;
        end else begin
            case (state)
                IDLE: if (desc_vld) begin
                    atx_chn_id  <= desc_chn_id;
                    atx_arid    <= desc_arid;
                    atx_awid    <= desc_awid;
                    atx_araddr  <= desc_src_addr & ~SRC_LOW;
                    atx_awaddr  <= desc_dst_addr & ~DST_LOW;
                    atx_arburst <= desc_arburst;
                    atx_awburst <= desc_awburst;
                    remaining   <= LEN_W'(desc_beats);
                end
                CALC: begin
                    len_q     <= calc_len;
                    atx_arlen <= ATX_LEN_W'(calc_len - LEN_W'(1));
                end
                ISSUE: if (atx_rdy) begin
                    remaining <= rem_next;
                    if (!src_fixed) atx_araddr <= atx_araddr + (SRC_ADDR_W'(len_q) << BEAT_SH);
                    if (!dst_fixed) atx_awaddr <= atx_awaddr + (DST_ADDR_W'(len_q) << BEAT_SH);
                end
                default: ;
            endcase
        end
    end

    assign atx_awlen     = atx_arlen;
    assign desc_rdy      = (state == IDLE);
    assign atx_vld       = (state == ISSUE);
    assign desc_done     = (state == DONE);
    assign desc_done_chn = atx_chn_id;
    assign busy          = (state != IDLE);

endmodule
